// File: rtl/intr_arbiter.sv
// intr_arbiter: bus interrupt arbiter for one BR level; optional SACK/INTR timeout via INTR_ARBITER_TIMEOUT_EN
module intr_arbiter #(
   parameter int NDEV     = 4,
   parameter int GRANTDLY = 3,
   parameter int TMOCYC   = 1023
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic [NDEV-1:0]   intreqs,
   input  logic [8*NDEV-1:0] irvecs,
   output logic [NDEV-1:0]   intgnts,
   output logic [7:0]        igvec,
   input  logic              init_in_h,
   input  logic              bg_in_h,
   output logic              bg_out_h,
   input  logic              bbsy_in_h,
   input  logic              ssyn_in_h,
   output logic              br_out_h,
   output logic              sack_out_h,
   output logic              bbsy_out_h,
   output logic              intr_out_h,
`ifdef INTR_ARBITER_TIMEOUT_EN
   output logic              tmoerr,
`endif
   output logic [15:0]       d_out_h
);

   typedef enum logic [2:0] {IDLE, REQ, PASS, SACK, INTR, DONE} state_t;

   if (NDEV < 1 || NDEV > 8 || GRANTDLY < 1 || GRANTDLY > 15 || TMOCYC < 1 || TMOCYC > 1023) begin : g_bad_param
      $error("intr_arbiter: parameter out of range");
   end

   state_t          state, state_d;
   logic [3:0]      bg_cnt;
   logic            bgok;
   logic [2:0]      win, win_d, lo_idx;
   logic [7:0]      vec, vec_d, lo_vec, igvec_d;
   logic            sack_d, bbsy_d, intr_d;
   logic [15:0]     dout_d;
   logic [NDEV-1:0] gnt_d;
`ifdef INTR_ARBITER_TIMEOUT_EN
   logic [9:0]      tmo_cnt;
   logic            tmoerr_d;
`endif

   assign bgok     = bg_cnt == 4'(GRANTDLY);
   assign br_out_h = (state == IDLE || state == REQ) && (intreqs != '0);
   assign bg_out_h = (state == PASS) && bg_in_h;

   // lowest-index active requester and its vector
   always_comb begin
      lo_idx = '0;
      lo_vec = '0;
      for (int i = NDEV - 1; i >= 0; i--)
         if (intreqs[i]) begin
            lo_idx = 3'(i);
            lo_vec = irvecs[8*i +: 8];
         end
   end

   // next state and next registered bus outputs
   always_comb begin
      state_d = state;
      sack_d  = sack_out_h;
      bbsy_d  = bbsy_out_h;
      intr_d  = intr_out_h;
      dout_d  = d_out_h;
      gnt_d   = '0;
      igvec_d = '0;
      win_d   = win;
      vec_d   = vec;
`ifdef INTR_ARBITER_TIMEOUT_EN
      tmoerr_d = tmoerr;
`endif
      case (state)
         IDLE, REQ:
            if (bgok && intreqs == '0)
               state_d = PASS;
            else if (bgok) begin
               state_d = SACK;
               sack_d  = 1'b1;
               win_d   = lo_idx;
               vec_d   = lo_vec;
            end else
               state_d = (intreqs != '0) ? REQ : IDLE;
         PASS:
            state_d = bg_in_h ? PASS : IDLE;
         SACK:
            if (!bg_in_h && !bbsy_in_h) begin
               state_d = INTR;
               sack_d  = 1'b0;
               bbsy_d  = 1'b1;
               intr_d  = 1'b1;
               dout_d  = {8'b0, vec};
            end
         INTR:
            if (ssyn_in_h) begin
               state_d = DONE;
               intr_d  = 1'b0;
               gnt_d   = NDEV'(1) << win;
               igvec_d = vec;
            end
         DONE:
            if (!ssyn_in_h) begin
               state_d = IDLE;
               bbsy_d  = 1'b0;
               dout_d  = '0;
            end
         default:
            state_d = IDLE;
      endcase
`ifdef INTR_ARBITER_TIMEOUT_EN
      if ((state == SACK || state == INTR) && tmo_cnt == 10'(TMOCYC)) begin
         state_d  = IDLE;
         sack_d   = 1'b0;
         bbsy_d   = 1'b0;
         intr_d   = 1'b0;
         dout_d   = '0;
         gnt_d    = '0;
         igvec_d  = '0;
         tmoerr_d = 1'b1;
      end
`endif
   end

   // state, grant deskew filter and registered outputs; INIT acts as a synchronous reset
   always_ff @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) begin
         state      <= IDLE;
         bg_cnt     <= '0;
         win        <= '0;
         vec        <= '0;
         sack_out_h <= 1'b0;
         bbsy_out_h <= 1'b0;
         intr_out_h <= 1'b0;
         d_out_h    <= '0;
         intgnts    <= '0;
         igvec      <= '0;
      end else if (init_in_h) begin
         state      <= IDLE;
         bg_cnt     <= '0;
         win        <= '0;
         vec        <= '0;
         sack_out_h <= 1'b0;
         bbsy_out_h <= 1'b0;
         intr_out_h <= 1'b0;
         d_out_h    <= '0;
         intgnts    <= '0;
         igvec      <= '0;
      end else begin
         state      <= state_d;
         bg_cnt     <= !bg_in_h ? 4'd0 : bgok ? bg_cnt : bg_cnt + 4'd1;
         win        <= win_d;
         vec        <= vec_d;
         sack_out_h <= sack_d;
         bbsy_out_h <= bbsy_d;
         intr_out_h <= intr_d;
         d_out_h    <= dout_d;
         intgnts    <= gnt_d;
         igvec      <= igvec_d;
      end

`ifdef INTR_ARBITER_TIMEOUT_EN
   // SSYN watchdog for SACK/INTR, restarted on every state change; sticky error flag
   always_ff @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) begin
         tmo_cnt <= '0;
         tmoerr  <= 1'b0;
      end else if (init_in_h) begin
         tmo_cnt <= '0;
         tmoerr  <= 1'b0;
      end else begin
         tmo_cnt <= (state_d == state && (state == SACK || state == INTR)) ? tmo_cnt + 10'd1 : 10'd0;
         tmoerr  <= tmoerr_d;
      end
`endif

endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter: randomized self-checking bench for intr_arbiter against a transaction-level model
module tb_intr_arbiter;

   localparam int NDEV = 4;
   localparam int GRANTDLY = 3;

   logic              CLOCK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [NDEV-1:0]   intreqs = '0;
   logic [7:0]        vecs [NDEV];
   logic [8*NDEV-1:0] irvecs;
   logic [NDEV-1:0]   intgnts;
   logic [7:0]        igvec;
   logic              init_in_h = 1'b0, bg_in_h = 1'b0, bbsy_in_h = 1'b0, ssyn_in_h = 1'b0;
   logic              bg_out_h, br_out_h, sack_out_h, bbsy_out_h, intr_out_h;
   logic [15:0]       d_out_h;
`ifdef INTR_ARBITER_TIMEOUT_EN
   logic              tmoerr;
`endif
   int                n_chk = 0, n_fail = 0;

   assign irvecs = {vecs[3], vecs[2], vecs[1], vecs[0]};

   always #5 CLOCK = ~CLOCK;

   intr_arbiter #(.NDEV(NDEV), .GRANTDLY(GRANTDLY)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .intreqs(intreqs), .irvecs(irvecs),
      .intgnts(intgnts), .igvec(igvec), .init_in_h(init_in_h), .bg_in_h(bg_in_h),
      .bg_out_h(bg_out_h), .bbsy_in_h(bbsy_in_h), .ssyn_in_h(ssyn_in_h),
      .br_out_h(br_out_h), .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h),
      .intr_out_h(intr_out_h),
`ifdef INTR_ARBITER_TIMEOUT_EN
      .tmoerr(tmoerr),
`endif
      .d_out_h(d_out_h)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   function automatic int lowest(input logic [NDEV-1:0] r);
      for (int i = 0; i < NDEV; i++)
         if (r[i]) return i;
      return -1;
   endfunction

   task automatic wait_sack(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (!sack_out_h && k < 20);
   endtask

   // one full processor-side service; device w with vector v is the expected winner
   task automatic serve(input int w, input logic [7:0] v);
      int k, hold, dly;
      check("br_before_grant", br_out_h, 1);
      bg_in_h = 1'b1;
      wait_sack(k);
      check("sack_latency", k, GRANTDLY + 1);
      check("bg_out_in_sack", bg_out_h, 0);
      check("br_in_sack", br_out_h, 0);
      step();
      check("sack_held", sack_out_h, 1);
      hold = $urandom_range(0, 3);
      bg_in_h = 1'b0;
      bbsy_in_h = (hold != 0);
      for (int i = 0; i < hold; i++) begin
         step();
         check("intr_waits_bbsy", intr_out_h, 0);
         check("sack_waits_bbsy", sack_out_h, 1);
      end
      bbsy_in_h = 1'b0;
      step();
      check("intr_up", intr_out_h, 1);
      check("bbsy_up", bbsy_out_h, 1);
      check("sack_down", sack_out_h, 0);
      check("d_out_vec", d_out_h, {8'b0, v});
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) begin
         step();
         check("no_gnt_before_ssyn", intgnts, 0);
      end
      ssyn_in_h = 1'b1;
      step();
      check("intgnts", intgnts, 32'(1) << w);
      check("igvec", igvec, v);
      check("intr_down", intr_out_h, 0);
      step();
      check("gnt_one_cycle", intgnts, 0);
      check("bbsy_held_done", bbsy_out_h, 1);
      ssyn_in_h = 1'b0;
      step();
      check("bbsy_released", bbsy_out_h, 0);
      check("d_out_cleared", d_out_h, 0);
   endtask

   initial begin
      int k;
      logic [NDEV-1:0] reqs;
      for (int i = 0; i < NDEV; i++) vecs[i] = '0;
      #12;
      check("rst_sack", sack_out_h, 0);
      check("rst_bbsy", bbsy_out_h, 0);
      check("rst_intr", intr_out_h, 0);
      check("rst_d", d_out_h, 0);
      check("rst_gnt", intgnts, 0);
      check("rst_br", br_out_h, 0);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      step();

      // single request, full handshake
      vecs[0] = 8'o120;
      intreqs = 4'b0001;
      step();
      serve(0, 8'o120);
      intreqs = '0;
      step();

      // priority: device 1 then device 3
      vecs[1] = 8'o120;
      vecs[3] = 8'o300;
      intreqs = 4'b1010;
      step();
      serve(1, 8'o120);
      intreqs = 4'b1000;
      step();
      serve(3, 8'o300);
      intreqs = '0;
      step();

      // grant pass-through with a request arriving mid-grant
      bg_in_h = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         check("pass_bg_out", bg_out_h, (i >= GRANTDLY + 1));
         check("pass_no_sack", sack_out_h, 0);
         if (i == 4) intreqs = 4'b0001;
      end
      bg_in_h = 1'b0;
      #1;
      check("pass_bg_drop", bg_out_h, 0);
      step();
      check("pass_br_after", br_out_h, 1);
      check("pass_no_sack_after", sack_out_h, 0);
      intreqs = '0;
      step();

      // glitch rejection
      intreqs = 4'b0100;
      step();
      bg_in_h = 1'b1;
      for (int i = 0; i < GRANTDLY - 1; i++) step();
      bg_in_h = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("glitch_no_sack", sack_out_h, 0);
         check("glitch_no_bg_out", bg_out_h, 0);
      end
      intreqs = '0;
      step();

      // INIT in INTR
      vecs[0] = 8'h55;
      intreqs = 4'b0001;
      bg_in_h = 1'b1;
      wait_sack(k);
      check("init_sack_seen", sack_out_h, 1);
      bg_in_h = 1'b0;
      step();
      check("init_in_intr", intr_out_h, 1);
      init_in_h = 1'b1;
      intreqs = '0;
      step();
      check("init_intr", intr_out_h, 0);
      check("init_bbsy", bbsy_out_h, 0);
      check("init_sack", sack_out_h, 0);
      check("init_d", d_out_h, 0);
      check("init_br", br_out_h, 0);
      check("init_bg_out", bg_out_h, 0);
      init_in_h = 1'b0;
      ssyn_in_h = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("init_no_gnt", intgnts, 0);
      end
      ssyn_in_h = 1'b0;
      step();

`ifdef INTR_ARBITER_TIMEOUT_EN
      // SSYN withheld in INTR
      vecs[1] = 8'o210;
      intreqs = 4'b0010;
      bg_in_h = 1'b1;
      wait_sack(k);
      bg_in_h = 1'b0;
      step();
      check("tmo_in_intr", intr_out_h, 1);
      k = 0;
      while (intr_out_h && k < 1100) begin
         step();
         k++;
      end
      check("tmo_intr_dropped", intr_out_h, 0);
      check("tmo_bbsy", bbsy_out_h, 0);
      check("tmo_d", d_out_h, 0);
      check("tmo_gnt", intgnts, 0);
      check("tmo_err", tmoerr, 1);
      step();
      check("tmo_br_again", br_out_h, 1);
      check("tmo_err_sticky", tmoerr, 1);
      intreqs = '0;
      init_in_h = 1'b1;
      step();
      init_in_h = 1'b0;
      check("tmo_err_cleared", tmoerr, 0);
      step();
`endif

      // randomized request sets served to exhaustion in model priority order
      for (int n = 0; n < 15; n++) begin
         reqs = NDEV'($urandom_range(1, (1 << NDEV) - 1));
         for (int i = 0; i < NDEV; i++) vecs[i] = 8'($urandom);
         intreqs = reqs;
         step();
         while (reqs != '0) begin
            k = lowest(reqs);
            serve(k, vecs[k]);
            reqs[k] = 1'b0;
            intreqs = reqs;
            step();
         end
         repeat ($urandom_range(1, 3)) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
- Bus interrupt arbiter for one bus-request level. Collects `intreq`/`irvec` from up to 8 local devices (xe11 ethernet, console, etc.).
- Runs the bus request/grant/SACK/INTR handshake toward the processor and returns a one-cycle `intgnt` and `igvec` to the device that was serviced.
- Sits directly downstream of each device's `intreq`/`irvec` outputs and upstream of their `intgnt`/`igvec` inputs.

Parameters:
- NDEV, 4, number of requesting devices, 1..8; index 0 is highest priority.
- GRANTDLY, 3, consecutive cycles `bg_in_h` must be seen high before it is acted on (deskew), 1..15.
- TMOCYC, 1023, cycles to wait for SSYN before abandoning a transaction (used only with the optional feature).

Ports:
- CLOCK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- intreqs  in  NDEV  per-device level interrupt request.
- irvecs  in  8*NDEV  per-device vector; bits [8i+7:8i] belong to device i.
- intgnts  out  NDEV  one-cycle grant pulse to the serviced device.
- igvec  out  8  vector delivered, valid while any `intgnts` bit is high.
- init_in_h  in  1  bus INIT.
- bg_in_h  in  1  bus grant arriving from the processor side.
- bg_out_h  out  1  bus grant passed to downstream devices.
- bbsy_in_h  in  1  bus busy from other masters.
- ssyn_in_h  in  1  slave sync from the processor.
- br_out_h  out  1  bus request.
- sack_out_h  out  1  selection acknowledge.
- bbsy_out_h  out  1  bus busy, driven while this block holds the bus.
- intr_out_h  out  1  interrupt strobe.
- d_out_h  out  16  data lines; carry {8'b0, vector} during INTR, 0 otherwise.

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs 0, state IDLE, grant filter counter 0.
- `init_in_h` high: same as reset, applied synchronously; it wins over every other event in that cycle.
- Grant filter: counter increments while `bg_in_h` is high, saturating at GRANTDLY, and clears when `bg_in_h` is low. "bgok" means counter == GRANTDLY.
- `br_out_h` = (state == IDLE or REQ) and (`intreqs` != 0). It is combinational from the registered state.
- States:
  - IDLE: if bgok and `intreqs` == 0 -> PASS. If bgok and `intreqs` != 0 -> latch winner = lowest set index and its vector, assert `sack_out_h` -> SACK. Otherwise, if `intreqs` != 0 -> REQ.
  - REQ: same grant checks as IDLE. If `intreqs` drops to 0 before a grant arrives -> IDLE.
  - PASS: `bg_out_h` = `bg_in_h`; a new request arriving mid-grant is never allowed to steal the grant. When `bg_in_h` goes low, drive `bg_out_h` 0 -> IDLE.
  - SACK: hold `sack_out_h`, wait for `bg_in_h` low and `bbsy_in_h` low -> assert `bbsy_out_h`, `intr_out_h`, `d_out_h` = vector, deassert `sack_out_h` -> INTR.
  - INTR: wait for `ssyn_in_h` high -> drop `intr_out_h`; pulse `intgnts[winner]` for exactly one cycle with `igvec` = vector -> DONE.
  - DONE: wait for `ssyn_in_h` low -> clear `d_out_h` and `bbsy_out_h` -> IDLE.
- The winner and its vector are latched at SACK entry. A requester that drops `intreq` after that point is still serviced with the latched vector; devices with level-triggered requests must tolerate this.
- Simultaneous requests: the lowest index wins; the others keep requesting and win in later cycles.
- `bg_out_h` is high only in PASS.
- `intgnts` is one-hot or zero, never more than one bit set.
- Minimum latency, bgok to SACK: 1 cycle. SSYN seen to `intgnts` pulse: 1 cycle.

Optional Feature:
- INTR_ARBITER_TIMEOUT_EN defined:
  - A 10-bit counter runs in SACK and INTR and clears on every state change.
  - When it reaches TMOCYC: drop all bus outputs, assert no `intgnts`, go to IDLE, and set sticky output `tmoerr` (extra 1-bit port) until reset or INIT.
  - The request is re-arbitrated normally afterwards.
- Undefined: no counter and no `tmoerr` port; SACK and INTR wait indefinitely.

Test Plan:
- Single request, full handshake: `intreqs`=0001, `irvecs[7:0]`=8'o120, BG held 5 cycles, then dropped, then SSYN -> `br_out_h` 1 while idle-requesting; `sack_out_h` 1 GRANTDLY+1 cycles after BG rises; `d_out_h`=16'o000120 with `intr_out_h`=1; `intgnts`=0001 for one cycle with `igvec`=8'o120; `bbsy_out_h` 0 after SSYN drops.
- Priority: `intreqs`=1010, vectors 8'o120/8'o300 at indices 1/3 -> first service delivers 8'o120 to `intgnts`=0010; device 1 drops its request; second service delivers 8'o300 with `intgnts`=1000.
- Grant pass-through: `intreqs`=0, BG high 6 cycles -> `bg_out_h` follows from cycle GRANTDLY+1; `intreqs` asserted mid-grant -> `bg_out_h` stays 1 until BG drops, no SACK.
- Glitch rejection: BG high for GRANTDLY-1 cycles with a request pending -> no SACK, no `bg_out_h`.
- INIT mid-INTR: assert `init_in_h` in INTR state -> next cycle all outputs 0, state IDLE, no `intgnts` pulse.
- Timeout (INTR_ARBITER_TIMEOUT_EN): withhold SSYN in INTR for TMOCYC cycles -> `intr_out_h`, `bbsy_out_h`, `d_out_h` go to 0; `tmoerr`=1; `br_out_h` reasserts next cycle.
